// File: rtl/nios_fprint_cpu_ocimem_ctrl_pkg.sv
// Shared types and constants for the on-chip debug monitor RAM controller.
// Holds the FSM state enum, jdo field positions and the default address width.
package nios_fprint_ocimem_pkg;

    localparam int unsigned DEF_ADDR_W     = 8;
    localparam int unsigned JDO_ADDR_LSB   = 26;
    localparam int unsigned JDO_RD_BIT     = 34;
    localparam int unsigned JDO_CLRERR_BIT = 35;
    localparam int unsigned JDO_WDATA_LSB  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_CAP,
        WR
    } ocimem_state_t;

endpackage

// File: rtl/nios_fprint_cpu_ocimem_ctrl_if.sv
// CPU debug slave port into the monitor RAM.
// The CPU side is the master; the controller is the slave.
interface nios_fprint_cpu_ocimem_ctrl_if #(
    parameter int unsigned ADDR_W = nios_fprint_ocimem_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic              cpu_debugaccess;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        input  cpu_readdata, cpu_waitrequest
    );

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, cpu_debugaccess,
        output cpu_readdata, cpu_waitrequest
    );
endinterface

// File: rtl/nios_fprint_cpu_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 monitor RAM: byte-enabled write, registered read (latency 1).
// Read-during-write returns the previous contents.
module nios_fprint_cpu_ocimem_ram
    import nios_fprint_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/nios_fprint_cpu_ocimem_ctrl.sv
// JTAG debug monitor RAM controller arbitrating against the CPU debug slave port.
// Optional macro NIOS_FPRINT_OCIMEM_WRPROT_EN write-protects words at and above WRPROT_BASE.
module nios_fprint_cpu_ocimem_ctrl
    import nios_fprint_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned WRPROT_BASE = 'hC0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [37:0]                  jdo,
    input  logic                         take_action_ocimem_a,
    input  logic                         take_action_ocimem_b,
    input  logic                         take_no_action_ocimem_a,
    nios_fprint_cpu_ocimem_ctrl_if.slave cpu,
    output logic [31:0]                  MonDReg,
    output logic                         monitor_ready,
    output logic                         monitor_error
);
`ifdef NIOS_FPRINT_OCIMEM_WRPROT_EN
    localparam bit WRPROT_EN = 1'b1;
`else
    localparam bit WRPROT_EN = 1'b0;
`endif

    ocimem_state_t     state;
    logic [ADDR_W-1:0] mon_areg;
    logic              rd_incr;
    logic              cpu_rd_pending;

    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic pulse_any, busy, cpu_req;
    logic cpu_accept_wr, cpu_accept_rd;
    logic jtag_wr_prot, cpu_wr_prot;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign pulse_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // An in-flight CPU read occupies the RAM port just like a JTAG operation.
    assign busy      = (state != IDLE) || cpu_rd_pending;
    assign cpu_req   = cpu.cpu_read || cpu.cpu_write;

    assign cpu_accept_wr = cpu.cpu_debugaccess && cpu.cpu_write && !busy && !pulse_any;
    assign cpu_accept_rd = cpu.cpu_debugaccess && cpu.cpu_read && !cpu.cpu_write
                           && !busy && !pulse_any;

    assign jtag_wr_prot = WRPROT_EN && (32'(mon_areg) >= WRPROT_BASE);
    assign cpu_wr_prot  = WRPROT_EN && (32'(cpu.cpu_address) >= WRPROT_BASE);

    always_comb begin
        cpu.cpu_waitrequest = 1'b0;
        if (cpu_req && cpu.cpu_debugaccess) begin
            if (cpu_rd_pending && cpu.cpu_read && !cpu.cpu_write) cpu.cpu_waitrequest = 1'b0;
            else if (cpu_accept_wr)                                cpu.cpu_waitrequest = 1'b0;
            else                                                   cpu.cpu_waitrequest = 1'b1;
        end
    end

    assign cpu.cpu_readdata = (cpu_rd_pending && cpu.cpu_debugaccess) ? ram_rdata : '0;

    always_comb begin
        ram_addr  = cpu.cpu_address;
        ram_wdata = cpu.cpu_writedata;
        ram_we    = '0;
        if (state == RD_ISSUE) begin
            ram_addr = mon_areg;
        end else if (state == WR) begin
            ram_addr  = mon_areg;
            ram_wdata = MonDReg;
            if (!jtag_wr_prot) ram_we = '1;
        end else if (cpu_accept_wr && !cpu_wr_prot) begin
            ram_we = cpu.cpu_byteenable;
        end
        if (reset) ram_we = '0;
    end

    nios_fprint_cpu_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            mon_areg       <= '0;
            MonDReg        <= '0;
            monitor_ready  <= 1'b1;
            monitor_error  <= 1'b0;
            rd_incr        <= 1'b0;
            cpu_rd_pending <= 1'b0;
        end else begin
            cpu_rd_pending <= cpu_accept_rd;
            case (state)
                RD_ISSUE: state <= RD_CAP;
                RD_CAP: begin
                    MonDReg       <= ram_rdata;
                    if (rd_incr) mon_areg <= mon_areg + ADDR_W'(1);
                    state         <= IDLE;
                    monitor_ready <= 1'b1;
                end
                WR: begin
                    if (jtag_wr_prot) monitor_error <= 1'b1;
                    mon_areg      <= mon_areg + ADDR_W'(1);
                    state         <= IDLE;
                    monitor_ready <= 1'b1;
                end
                default: ;
            endcase
            // Pulses are only acted on when idle, so they never collide with the case above.
            if (pulse_any) begin
                if (busy) begin
                    monitor_error <= 1'b1;
                end else if (take_action_ocimem_a) begin
                    mon_areg <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    if (jdo[JDO_CLRERR_BIT]) monitor_error <= 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state         <= RD_ISSUE;
                        rd_incr       <= 1'b0;
                        monitor_ready <= 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    MonDReg       <= jdo[JDO_WDATA_LSB +: 32];
                    state         <= WR;
                    monitor_ready <= 1'b0;
                end else begin
                    state         <= RD_ISSUE;
                    rd_incr       <= 1'b1;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nios_fprint_cpu_ocimem_ctrl.sv
// Directed scoreboard bench for nios_fprint_cpu_ocimem_ctrl (JTAG path, CPU arbitration, reset).
// Protection checks are built only when NIOS_FPRINT_OCIMEM_WRPROT_EN is defined.
module tb_nios_fprint_cpu_ocimem_ctrl;
    import nios_fprint_ocimem_pkg::*;

    localparam int unsigned AW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
    logic [31:0] mon_d;
    logic        mon_ready, mon_err;

    nios_fprint_cpu_ocimem_ctrl_if #(.ADDR_W(AW)) cpu_bus ();

    nios_fprint_cpu_ocimem_ctrl #(.ADDR_W(AW), .WRPROT_BASE(32'hC0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .cpu                     (cpu_bus),
        .MonDReg                 (mon_d),
        .monitor_ready           (mon_ready),
        .monitor_error           (mon_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0]   model [256];
    logic [AW-1:0] mon_a = '0;
    logic [31:0]   exp_q [$];
    logic [31:0]   cpu_q [$];

    function automatic bit prot(input logic [AW-1:0] a);
`ifdef NIOS_FPRINT_OCIMEM_WRPROT_EN
        return a >= 8'hC0;
`else
        return (a != a);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int exp_lat, input string tag);
        int n = 0;
        while (!mon_ready && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic jtag_a(input logic [AW-1:0] addr, input logic rd, input logic clr, input string tag);
        jdo = '0;
        jdo[JDO_ADDR_LSB +: AW] = addr;
        jdo[JDO_RD_BIT]         = rd;
        jdo[JDO_CLRERR_BIT]     = clr;
        mon_a = addr;
        if (rd) exp_q.push_back(model[addr]);
        ta_a = 1'b1;
        tick;
        ta_a = 1'b0;
        if (rd) begin
            wait_ready(2, tag);
            check({tag, "_data"}, mon_d, exp_q.pop_front());
        end
    endtask

    task automatic jtag_b(input logic [31:0] data, input string tag);
        jdo = '0;
        jdo[JDO_WDATA_LSB +: 32] = data;
        ta_b = 1'b1;
        tick;
        ta_b = 1'b0;
        wait_ready(1, tag);
        if (!prot(mon_a)) model[mon_a] = data;
        mon_a++;
    endtask

    task automatic jtag_n(input string tag);
        exp_q.push_back(model[mon_a]);
        mon_a++;
        tn_a = 1'b1;
        tick;
        tn_a = 1'b0;
        wait_ready(2, tag);
        check({tag, "_data"}, mon_d, exp_q.pop_front());
    endtask

    task automatic cpu_wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be,
                          input logic dbg, input string tag);
        cpu_bus.cpu_address     = addr;
        cpu_bus.cpu_writedata   = data;
        cpu_bus.cpu_byteenable  = be;
        cpu_bus.cpu_debugaccess = dbg;
        cpu_bus.cpu_write       = 1'b1;
        #1;
        check({tag, "_wait"}, 32'(cpu_bus.cpu_waitrequest), 32'(0));
        tick;
        cpu_bus.cpu_write       = 1'b0;
        cpu_bus.cpu_debugaccess = 1'b1;
        if (dbg && !prot(addr)) begin
            for (int b = 0; b < 4; b++) if (be[b]) model[addr][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic cpu_rd(input logic [AW-1:0] addr, input logic dbg, input string tag);
        int n = 0;
        cpu_q.push_back(dbg ? model[addr] : 32'h0);
        cpu_bus.cpu_address     = addr;
        cpu_bus.cpu_debugaccess = dbg;
        cpu_bus.cpu_read        = 1'b1;
        #1;
        while (cpu_bus.cpu_waitrequest && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_waitcyc"}, 32'(n), dbg ? 32'(1) : 32'(0));
        check({tag, "_data"}, cpu_bus.cpu_readdata, cpu_q.pop_front());
        tick;
        cpu_bus.cpu_read        = 1'b0;
        cpu_bus.cpu_debugaccess = 1'b1;
    endtask

    task automatic jtag_peek(input logic [AW-1:0] addr, input string tag, output logic [31:0] v);
        jdo = '0;
        jdo[JDO_ADDR_LSB +: AW] = addr;
        jdo[JDO_RD_BIT]         = 1'b1;
        mon_a = addr;
        ta_a = 1'b1;
        tick;
        ta_a = 1'b0;
        wait_ready(2, tag);
        v = mon_d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] v0, v1;
        cpu_bus.cpu_address     = '0;
        cpu_bus.cpu_read        = 1'b0;
        cpu_bus.cpu_write       = 1'b0;
        cpu_bus.cpu_writedata   = '0;
        cpu_bus.cpu_byteenable  = '0;
        cpu_bus.cpu_debugaccess = 1'b1;
        repeat (3) tick;
        reset = 1'b0;

        check("rst_ready", 32'(mon_ready), 32'(1));
        check("rst_mondreg", mon_d, 32'h0);
        check("rst_error", 32'(mon_err), 32'(0));
        check("rst_wait", 32'(cpu_bus.cpu_waitrequest), 32'(0));
        check("rst_rdata", cpu_bus.cpu_readdata, 32'h0);

        // JTAG write, auto-increment, readback
        jtag_a(8'h10, 1'b0, 1'b0, "wr_addr");
        jtag_b(32'hDEADBEEF, "wr_10");
        jtag_b(32'h01234567, "wr_11");
        jtag_a(8'h10, 1'b1, 1'b0, "rd_10");
        jtag_a(8'h11, 1'b1, 1'b0, "rd_11");

        // Address wrap on write and on read
        jtag_a(8'h00, 1'b0, 1'b0, "wrap_a0");
        jtag_b(32'h00C0FFEE, "wrap_w0");
        jtag_a(8'hFF, 1'b0, 1'b0, "wrap_aff");
        jtag_b(32'hFEEDFACE, "wrap_wff");
        jtag_b(32'h0A0B0C0D, "wrap_w0b");
        jtag_a(8'hFF, 1'b0, 1'b0, "wrap_aff2");
        jtag_n("wrap_nff");
        jtag_n("wrap_n00");

        // Tie: JTAG write and CPU read to the same word in one cycle
        jtag_a(8'h20, 1'b0, 1'b0, "tie_addr");
        cpu_q.push_back(32'hCAFEF00D);
        jdo = '0;
        jdo[JDO_WDATA_LSB +: 32] = 32'hCAFEF00D;
        ta_b = 1'b1;
        cpu_bus.cpu_address = 8'h20;
        cpu_bus.cpu_read    = 1'b1;
        #1;
        check("tie_wait_first", 32'(cpu_bus.cpu_waitrequest), 32'(1));
        tick;
        ta_b = 1'b0;
        n = 0;
        while (cpu_bus.cpu_waitrequest && n < 20) begin
            tick;
            n++;
        end
        check("tie_done", 32'(n < 20), 32'(1));
        check("tie_data", cpu_bus.cpu_readdata, cpu_q.pop_front());
        tick;
        cpu_bus.cpu_read = 1'b0;
        model[8'h20] = 32'hCAFEF00D;
        mon_a = 8'h21;
        check("tie_ready", 32'(mon_ready), 32'(1));

        // Busy: second pulse one cycle after a read pulse is dropped
        jtag_a(8'h40, 1'b0, 1'b0, "busy_addr");
        jtag_b(32'h55AA33CC, "busy_w");
        jdo = '0;
        jdo[JDO_ADDR_LSB +: AW] = 8'h40;
        jdo[JDO_RD_BIT] = 1'b1;
        mon_a = 8'h40;
        exp_q.push_back(model[8'h40]);
        ta_a = 1'b1;
        tick;
        ta_a = 1'b0;
        tn_a = 1'b1;
        tick;
        tn_a = 1'b0;
        check("busy_err", 32'(mon_err), 32'(1));
        wait_ready(1, "busy_rd");
        check("busy_data", mon_d, exp_q.pop_front());
        jtag_n("busy_noinc");
        check("busy_err_sticky", 32'(mon_err), 32'(1));
        jtag_a(8'h00, 1'b0, 1'b1, "clr");
        check("clr_err", 32'(mon_err), 32'(0));

        // CPU byte lanes and debugaccess gating
        cpu_wr(8'h30, 32'hAAAA5555, 4'b1111, 1'b1, "cpu_full");
        cpu_wr(8'h30, 32'h12345678, 4'b0011, 1'b1, "cpu_be");
        cpu_rd(8'h30, 1'b1, "cpu_rd_be");
        cpu_wr(8'h30, 32'hFFFFFFFF, 4'b1111, 1'b0, "cpu_nodbg_wr");
        cpu_rd(8'h30, 1'b0, "cpu_nodbg_rd");
        cpu_rd(8'h30, 1'b1, "cpu_rd_after");
        jtag_a(8'h30, 1'b1, 1'b0, "jtag_sees_cpu");
        check("cpu_no_err", 32'(mon_err), 32'(0));

        // Reset during RD_ISSUE aborts the read
        jdo = '0;
        jdo[JDO_ADDR_LSB +: AW] = 8'h10;
        jdo[JDO_RD_BIT] = 1'b1;
        ta_a = 1'b1;
        tick;
        ta_a = 1'b0;
        check("midrst_busy", 32'(mon_ready), 32'(0));
        reset = 1'b1;
        tick;
        check("midrst_ready", 32'(mon_ready), 32'(1));
        check("midrst_mondreg", mon_d, 32'h0);
        reset = 1'b0;
        mon_a = '0;
        jtag_b(32'h0BADC0DE, "midrst_w0");
        jtag_a(8'h00, 1'b1, 1'b0, "midrst_rd0");

`ifdef NIOS_FPRINT_OCIMEM_WRPROT_EN
        jtag_peek(8'hC4, "wp_pre", v0);
        jtag_a(8'hC4, 1'b0, 1'b1, "wp_addr");
        jtag_b(32'h5A5A5A5A, "wp_jwr");
        check("wp_jerr", 32'(mon_err), 32'(1));
        tn_a = 1'b1;
        tick;
        tn_a = 1'b0;
        wait_ready(2, "wp_next");
        v1 = mon_d;
        jtag_peek(8'hC5, "wp_c5", v0);
        check("wp_inc", v1, v0);
        jtag_peek(8'hC4, "wp_post", v1);
        jtag_peek(8'hC4, "wp_post2", v0);
        check("wp_unchanged_stable", v1, v0);
        check("wp_not_written", 32'(v1 == 32'h5A5A5A5A), 32'(0));
        jtag_a(8'h00, 1'b0, 1'b1, "wp_clr");
        jtag_peek(8'hC8, "wp_cpre", v0);
        cpu_wr(8'hC8, ~v0, 4'b1111, 1'b1, "wp_cwr");
        jtag_peek(8'hC8, "wp_cpost", v1);
        check("wp_cpu_unchanged", v1, v0);
        check("wp_cpu_noerr", 32'(mon_err), 32'(0));
`else
        v0 = '0;
        v1 = '0;
        jtag_a(8'hC4, 1'b0, 1'b0, "open_addr");
        jtag_b(32'h5A5A5A5A, "open_wr");
        jtag_a(8'hC4, 1'b1, 1'b0, "open_rd");
        check("open_noerr", 32'(mon_err), 32'(v0 | v1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
